// File: rtl/prio_irq_ctrl_pkg.sv
// Shared definitions for the prio_irq_ctrl interrupt controller: register
// offsets, claim-FSM states and the byte-address decoder.
package prio_irq_ctrl_pkg;

  localparam logic [7:0] ADDR_STATUS   = 8'h00;
  localparam logic [7:0] ADDR_MASK     = 8'h04;
  localparam logic [7:0] ADDR_MODE     = 8'h08;
  localparam logic [7:0] ADDR_CLEAR    = 8'h0C;
  localparam logic [7:0] ADDR_CLAIM    = 8'h10;
  localparam logic [7:0] ADDR_COMPLETE = 8'h14;

  localparam int CLAIM_VALID_BIT = 31;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CLAIMED = 1'b1
  } state_e;

  typedef struct packed {
    logic status;
    logic mask;
    logic mode;
    logic clear;
    logic claim;
    logic complete;
  } reg_hit_t;

  function automatic reg_hit_t decode_addr(input logic [7:0] addr);
    reg_hit_t hit;
    hit          = '0;
    hit.status   = (addr == ADDR_STATUS);
    hit.mask     = (addr == ADDR_MASK);
    hit.mode     = (addr == ADDR_MODE);
    hit.clear    = (addr == ADDR_CLEAR);
    hit.claim    = (addr == ADDR_CLAIM);
    hit.complete = (addr == ADDR_COMPLETE);
    return hit;
  endfunction

endpackage

// File: rtl/prio_irq_enc.sv
// Lowest-index-wins priority encoder over a NUM_IRQ request vector.
module prio_irq_enc #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);

  // Scanning from the top down lets the lowest set index overwrite the rest.
  always_comb begin
    valid_o = |req_i;
    id_o    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/prio_irq_ctrl.sv
// APB interrupt controller with per-source level/edge mode, mask, clear and a
// claim/complete handshake. Define IRQ_SYNC_EN to add a 2-flop input synchroniser.
module prio_irq_ctrl
  import prio_irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               pclk_i,
  input  logic               rst_i,
  input  logic               psel_i,
  input  logic               penable_i,
  input  logic               pwrite_i,
  input  logic [31:0]        paddr_i,
  input  logic [31:0]        pwdata_i,
  output logic [31:0]        prdata_o,
  output logic               pready_o,
  output logic               pslverr_o,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               interrupt_o
);

  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] samp_q, samp_d, prev_q, prev_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d, mode_q, mode_d;
  logic [ID_W-1:0]    in_service_q, in_service_d;
  logic [31:0]        prdata_q, prdata_d;
  logic               interrupt_q, interrupt_d;
  state_e             state_q, state_d;

  logic [NUM_IRQ-1:0] mode_chg, clr_vec, claim_clr, edge_set, edge_pend;
  logic               enc_valid;
  logic [ID_W-1:0]    enc_id;
  reg_hit_t           hit;
  logic               setup_rd, acc_wr, acc_rd, claim_fire, complete_ok;
  logic               unused_bits;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_i;
`endif

  assign hit         = decode_addr(paddr_i[7:0]);
  assign setup_rd    = psel_i & ~penable_i & ~pwrite_i;
  assign acc_wr      = psel_i & penable_i & pwrite_i;
  assign acc_rd      = psel_i & penable_i & ~pwrite_i;
  assign complete_ok = acc_wr & hit.complete & (state_q == ST_CLAIMED) &
                       (pwdata_i[ID_W-1:0] == in_service_q);
  // The claim acts on the ID captured in the setup phase, not a fresh encode.
  assign claim_fire  = acc_rd & hit.claim & (state_q == ST_IDLE) &
                       prdata_q[CLAIM_VALID_BIT];

  assign pslverr_o = (acc_wr | acc_rd) &
                     (~(|hit) |
                      (acc_wr & (hit.status | hit.claim)) |
                      (acc_rd & (hit.clear | hit.complete)) |
                      (acc_wr & hit.complete & ~complete_ok));

  assign pready_o    = 1'b1;
  assign prdata_o    = prdata_q;
  assign interrupt_o = interrupt_q;
  assign unused_bits = ^{paddr_i[31:8], pwdata_i};

  prio_irq_enc #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_enc (
    .req_i   (pending_q & mask_q),
    .valid_o (enc_valid),
    .id_o    (enc_id)
  );

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    mask_d       = mask_q;
    mode_d       = mode_q;
    state_d      = state_q;
    in_service_d = in_service_q;
    prdata_d     = prdata_q;
    mode_chg     = '0;
    clr_vec      = '0;
    claim_clr    = '0;

    if (acc_wr && hit.mask) mask_d = pwdata_i[NUM_IRQ-1:0];
    if (acc_wr && hit.mode) begin
      mode_d   = pwdata_i[NUM_IRQ-1:0];
      mode_chg = pwdata_i[NUM_IRQ-1:0] ^ mode_q;
    end
    if (acc_wr && hit.clear) clr_vec = pwdata_i[NUM_IRQ-1:0];

    if (claim_fire) begin
      state_d      = ST_CLAIMED;
      in_service_d = prdata_q[ID_W-1:0];
      claim_clr    = (NUM_IRQ'(1) << prdata_q[ID_W-1:0]) & mode_q;
    end else if (complete_ok) begin
      state_d = ST_IDLE;
    end

    // A mode change restarts edge history: no stale edge, no stale pending.
    edge_set  = samp_q & ~prev_q & ~mode_chg;
    edge_pend = edge_set | (pending_q & ~(clr_vec | claim_clr));
    pending_d = ((mode_q & edge_pend) | (~mode_q & samp_q)) & ~mode_chg;
    samp_d    = irq_s;
    prev_d    = (samp_q & ~mode_chg) | (irq_s & mode_chg);

    if (setup_rd) begin
      prdata_d = '0;
      case (paddr_i[7:0])
        ADDR_STATUS: prdata_d[NUM_IRQ-1:0] = pending_q;
        ADDR_MASK:   prdata_d[NUM_IRQ-1:0] = mask_q;
        ADDR_MODE:   prdata_d[NUM_IRQ-1:0] = mode_q;
        ADDR_CLAIM: begin
          if (state_q == ST_IDLE && enc_valid) begin
            prdata_d[CLAIM_VALID_BIT] = 1'b1;
            prdata_d[ID_W-1:0]        = enc_id;
          end
        end
        default: ;
      endcase
    end

    interrupt_d = (state_q == ST_IDLE) & enc_valid;
  end

  // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      samp_q       <= '0;
      prev_q       <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      mode_q       <= '0;
      in_service_q <= '0;
      prdata_q     <= '0;
      interrupt_q  <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      samp_q       <= samp_d;
      prev_q       <= prev_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      mode_q       <= mode_d;
      in_service_q <= in_service_d;
      prdata_q     <= prdata_d;
      interrupt_q  <= interrupt_d;
      state_q      <= state_d;
    end
  end

endmodule

// File: tb/tb_prio_irq_ctrl.sv
// Self-checking bench for prio_irq_ctrl: register-access vector table plus
// hand-written claim/complete, clear and reset sequences.
module tb_prio_irq_ctrl;

  localparam int N = 8;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst, psel, penable, pwrite;
  logic [31:0]   paddr, pwdata, prdata;
  logic          pready, pslverr, intr;
  logic [N-1:0]  irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;
  vec_t vt[19];

  always #5 clk = ~clk;

  prio_irq_ctrl #(.NUM_IRQ(N)) dut (
    .pclk_i      (clk),
    .rst_i       (rst),
    .psel_i      (psel),
    .penable_i   (penable),
    .pwrite_i    (pwrite),
    .paddr_i     (paddr),
    .pwdata_i    (pwdata),
    .prdata_o    (prdata),
    .pready_o    (pready),
    .pslverr_o   (pslverr),
    .irq_i       (irq),
    .interrupt_o (intr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input logic exp, input string nm);
    check(nm, {31'b0, intr}, {31'b0, exp});
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e,
                    input string nm);
    exp_t e;
    exp_t got;
    e.name = nm; e.data = exp_d; e.err = exp_e;
    sb_q.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    step();
    penable = 1'b1;
    #1;
    got = sb_q.pop_front();
    if (!got.err) check({got.name, ".rdata"}, prdata, got.data);
    check({got.name, ".err"}, {31'b0, pslverr}, {31'b0, got.err});
    step();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic exp_e,
                    input string nm);
    exp_t e;
    exp_t got;
    e.name = nm; e.data = '0; e.err = exp_e;
    sb_q.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    step();
    penable = 1'b1;
    #1;
    got = sb_q.pop_front();
    check({got.name, ".err"}, {31'b0, pslverr}, {31'b0, got.err});
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    // {is_wr, addr, wdata, expected rdata, expected pslverr}; irq held low
    vt[0]  = '{1'b0, 32'h00,  32'h0,        32'h0,  1'b0};
    vt[1]  = '{1'b0, 32'h04,  32'h0,        32'h0,  1'b0};
    vt[2]  = '{1'b0, 32'h08,  32'h0,        32'h0,  1'b0};
    vt[3]  = '{1'b0, 32'h10,  32'h0,        32'h0,  1'b0};
    vt[4]  = '{1'b1, 32'h04,  32'hFFFF_FFA5, 32'h0, 1'b0};
    vt[5]  = '{1'b0, 32'h04,  32'h0,        32'hA5, 1'b0};
    vt[6]  = '{1'b1, 32'h08,  32'h0000_013C, 32'h0, 1'b0};
    vt[7]  = '{1'b0, 32'h08,  32'h0,        32'h3C, 1'b0};
    vt[8]  = '{1'b0, 32'h18,  32'h0,        32'h0,  1'b1};
    vt[9]  = '{1'b1, 32'h00,  32'h12,       32'h0,  1'b1};
    vt[10] = '{1'b0, 32'h00,  32'h0,        32'h0,  1'b0};
    vt[11] = '{1'b0, 32'h0C,  32'h0,        32'h0,  1'b1};
    vt[12] = '{1'b0, 32'h14,  32'h0,        32'h0,  1'b1};
    vt[13] = '{1'b1, 32'h10,  32'h0,        32'h0,  1'b1};
    vt[14] = '{1'b1, 32'h14,  32'h0,        32'h0,  1'b1};
    vt[15] = '{1'b0, 32'h104, 32'h0,        32'hA5, 1'b0};
    vt[16] = '{1'b1, 32'h04,  32'h0,        32'h0,  1'b0};
    vt[17] = '{1'b1, 32'h08,  32'h0,        32'h0,  1'b0};
    vt[18] = '{1'b0, 32'h02,  32'h0,        32'h0,  1'b1};

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; irq = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset.prdata", prdata, 32'h0);
    chk_int(1'b0, "reset.interrupt");
    check("reset.pslverr", {31'b0, pslverr}, 32'h0);
    check("reset.pready", {31'b0, pready}, 32'h1);

    for (int i = 0; i < 19; i++) begin
      if (vt[i].is_wr) wr(vt[i].addr, vt[i].wdata, vt[i].exp_e, $sformatf("vec%0d", i));
      else             rd(vt[i].addr, vt[i].exp_d, vt[i].exp_e, $sformatf("vec%0d", i));
    end

    // Level source 0: latency and release
    wr(32'h04, 32'h01, 1'b0, "lvl.mask");
    irq[0] = 1'b1;
    repeat (LAT) step();
    chk_int(1'b0, "lvl.int_early");
    step();
    chk_int(1'b1, "lvl.int_on");
    rd(32'h00, 32'h01, 1'b0, "lvl.status_on");
    irq[0] = 1'b0;
    repeat (LAT + 2) step();
    chk_int(1'b0, "lvl.int_off");
    rd(32'h00, 32'h00, 1'b0, "lvl.status_off");

    // Edge sources 5 and 2 pulsed together: claim order and handshake
    wr(32'h04, 32'hFF, 1'b0, "edge.mask");
    wr(32'h08, 32'hFF, 1'b0, "edge.mode");
    irq = 8'h24;
    step();
    irq = 8'h00;
    repeat (LAT + 1) step();
    chk_int(1'b1, "edge.int_on");
    rd(32'h00, 32'h24, 1'b0, "edge.status");
    rd(32'h10, 32'h8000_0002, 1'b0, "edge.claim2");
    step();
    chk_int(1'b0, "edge.int_claimed");
    rd(32'h00, 32'h20, 1'b0, "edge.status_after_claim");
    rd(32'h10, 32'h0, 1'b0, "edge.claim_nested");
    wr(32'h14, 32'h7, 1'b1, "edge.complete7");
    wr(32'h14, 32'h5, 1'b1, "edge.complete5_wrong");
    chk_int(1'b0, "edge.int_still_claimed");
    wr(32'h14, 32'h2, 1'b0, "edge.complete2");
    step();
    chk_int(1'b1, "edge.int_reassert");
    rd(32'h10, 32'h8000_0005, 1'b0, "edge.claim5");
    step();
    chk_int(1'b0, "edge.int_claimed5");
    wr(32'h14, 32'h5, 1'b0, "edge.complete5");
    repeat (2) step();
    chk_int(1'b0, "edge.int_idle_empty");
    rd(32'h00, 32'h00, 1'b0, "edge.status_empty");

    // CLEAR colliding with a new rising edge on source 3: set wins
    irq = 8'h08;
    step();
    irq = 8'h00;
    repeat (LAT + 1) step();
    rd(32'h00, 32'h08, 1'b0, "clr.status_pending");
    irq = 8'h08;
    repeat (LAT - 2) step();
    wr(32'h0C, 32'h08, 1'b0, "clr.collide");
    rd(32'h00, 32'h08, 1'b0, "clr.set_wins");
    wr(32'h0C, 32'h08, 1'b0, "clr.plain");
    rd(32'h00, 32'h00, 1'b0, "clr.cleared");
    irq = 8'h00;

    // CLEAR has no effect on a level source
    wr(32'h08, 32'h00, 1'b0, "lvlclr.mode");
    irq = 8'h02;
    repeat (LAT + 1) step();
    wr(32'h0C, 32'h02, 1'b0, "lvlclr.clear");
    rd(32'h00, 32'h02, 1'b0, "lvlclr.status");

    // Masked priority, then reset while claimed
    irq = 8'h52;
    wr(32'h04, 32'h50, 1'b0, "rst.mask");
    repeat (LAT + 1) step();
    rd(32'h10, 32'h8000_0004, 1'b0, "rst.claim_masked_prio");
    rd(32'h00, 32'h52, 1'b0, "rst.status_level");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_int(1'b0, "rst.int_after_reset");
    rd(32'h00, 32'h00, 1'b0, "rst.pending_discarded");
    rd(32'h04, 32'h00, 1'b0, "rst.mask_reset");
    wr(32'h04, 32'h50, 1'b0, "rst.mask_again");
    repeat (LAT + 1) step();
    rd(32'h10, 32'h8000_0004, 1'b0, "rst.fresh_claim");
    wr(32'h14, 32'h4, 1'b0, "rst.complete");
    irq = 8'h00;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
